// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM march BIST: FSM state encoding, march element
// and address direction codes, and the RAM depth derivation.
package ram_bist_pkg;

   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StM0W  = 3'd1,
      StM1R  = 3'd2,
      StM1W  = 3'd3,
      StM2R  = 3'd4,
      StM2W  = 3'd5,
      StM3R  = 3'd6,
      StDone = 3'd7
   } state_t;

   typedef enum logic [1:0] {
      ElemM0 = 2'd0,
      ElemM1 = 2'd1,
      ElemM2 = 2'd2,
      ElemM3 = 2'd3
   } elem_t;

   typedef enum logic {
      DirUp   = 1'b0,
      DirDown = 1'b1
   } dir_t;

   function automatic int unsigned depth_of(input int unsigned aw);
      return 32'd1 << aw;
   endfunction

   // IDLE/DONE map to M0 purely so the address generator sees a defined direction.
   function automatic elem_t elem_of(input state_t s);
      case (s)
         StM1R, StM1W: return ElemM1;
         StM2R, StM2W: return ElemM2;
         StM3R:        return ElemM3;
         default:      return ElemM0;
      endcase
   endfunction

   function automatic dir_t dir_of(input elem_t e);
      return (e == ElemM2 || e == ElemM3) ? DirDown : DirUp;
   endfunction

   function automatic logic is_read(input state_t s);
      return (s == StM1R) || (s == StM2R) || (s == StM3R);
   endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Loadable up/down address counter for the march BIST with a terminal-count flag that
// marks the last address of the current sweep direction.
module ram_bist_addr_gen
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_load,
   input  logic              i_load_top,
   input  logic              i_step,
   input  dir_t              i_dir,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_term
);

   localparam logic [ADDR_W-1:0] TopAddr = ADDR_W'(depth_of(ADDR_W) - 1);

   logic [ADDR_W-1:0] r_addr;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_addr <= '0;
      end else if (i_load) begin
         r_addr <= i_load_top ? TopAddr : '0;
      end else if (i_step) begin
         r_addr <= (i_dir == DirDown) ? r_addr - ADDR_W'(1) : r_addr + ADDR_W'(1);
      end
   end

   assign o_addr = r_addr;
   assign o_term = (i_dir == DirDown) ? (r_addr == '0) : (r_addr == TopAddr);

endmodule

// File: rtl/ram_march_bist.sv
// March BIST initiator for a single-port async-read RAM: runs a 4-element march with a
// latched background pattern and reports pass plus the first failing address and data.
module ram_march_bist
   import ram_bist_pkg::*;
#(
   parameter int unsigned ADDR_W       = 4,
   parameter int unsigned DATA_W       = 8,
   parameter int unsigned STOP_ON_FAIL = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_pattern,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_pass,
   output logic [ADDR_W-1:0] o_fail_addr,
   output logic [DATA_W-1:0] o_fail_data,
   output logic              o_ram_we,
   output logic [ADDR_W-1:0] o_ram_addr,
   output logic [DATA_W-1:0] o_ram_wdata,
   input  logic [DATA_W-1:0] i_ram_rdata
);

   state_t            r_state;
   logic [DATA_W-1:0] r_pattern;
   logic              r_busy;
   logic              r_done;
   logic              r_pass;
   logic              r_mis;
   logic [ADDR_W-1:0] r_fail_addr;
   logic [DATA_W-1:0] r_fail_data;
   logic              r_we;
   logic [DATA_W-1:0] r_wdata;

   elem_t             w_elem;
   dir_t              w_dir;
   logic [ADDR_W-1:0] w_addr;
   logic              w_term;
   logic              w_load;
   logic              w_load_top;
   logic              w_step;
   logic [DATA_W-1:0] w_expect;
   logic              w_mismatch;

   assign w_elem     = elem_of(r_state);
   assign w_dir      = dir_of(w_elem);
   assign w_expect   = (w_elem == ElemM2) ? ~r_pattern : r_pattern;
   assign w_mismatch = is_read(r_state) && (i_ram_rdata != w_expect);

   // Address moves after each write (or after the read in M3); terminal loads the next start.
   always_comb begin
      w_load     = 1'b0;
      w_load_top = 1'b0;
      w_step     = 1'b0;
      case (r_state)
         StIdle: w_load = i_start;
         StM0W: begin
            w_load = w_term;
            w_step = !w_term;
         end
         StM1W, StM2W: begin
            w_load     = w_term;
            w_load_top = w_term;
            w_step     = !w_term;
         end
         StM3R:   w_step = !w_term;
         default: ;
      endcase
   end

   ram_bist_addr_gen #(
      .ADDR_W(ADDR_W)
   ) u_addr_gen (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_load    (w_load),
      .i_load_top(w_load_top),
      .i_step    (w_step),
      .i_dir     (w_dir),
      .o_addr    (w_addr),
      .o_term    (w_term)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_pattern   <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_mis       <= 1'b0;
         r_fail_addr <= '0;
         r_fail_data <= '0;
         r_we        <= 1'b0;
         r_wdata     <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            StIdle: begin
               if (i_start) begin
                  r_state     <= StM0W;
                  r_pattern   <= i_pattern;
                  r_busy      <= 1'b1;
                  r_we        <= 1'b1;
                  r_wdata     <= i_pattern;
                  r_pass      <= 1'b0;
                  r_mis       <= 1'b0;
                  r_fail_addr <= '0;
                  r_fail_data <= '0;
               end
            end
            StM0W: begin
               if (w_term) begin
                  r_state <= StM1R;
                  r_we    <= 1'b0;
               end
            end
            StM1R: begin
               r_state <= StM1W;
               r_we    <= 1'b1;
               r_wdata <= ~r_pattern;
            end
            StM1W: begin
               r_state <= w_term ? StM2R : StM1R;
               r_we    <= 1'b0;
            end
            StM2R: begin
               r_state <= StM2W;
               r_we    <= 1'b1;
               r_wdata <= r_pattern;
            end
            StM2W: begin
               r_state <= w_term ? StM3R : StM2R;
               r_we    <= 1'b0;
            end
            StM3R: begin
               if (w_term) begin
                  r_state <= StDone;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= !(r_mis || w_mismatch);
               end
            end
            StDone:  r_state <= StIdle;
            default: r_state <= StIdle;
         endcase

         // Only the first mismatch of a run is captured; later ones just keep r_mis set.
         if (w_mismatch) begin
            r_mis <= 1'b1;
            if (!r_mis) begin
               r_fail_addr <= w_addr;
               r_fail_data <= i_ram_rdata;
            end
            if (STOP_ON_FAIL != 0) begin
               r_state <= StDone;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
               r_pass  <= 1'b0;
               r_we    <= 1'b0;
            end
         end
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_fail_addr = r_fail_addr;
   assign o_fail_data = r_fail_data;
   assign o_ram_we    = r_we;
   assign o_ram_addr  = w_addr;
   assign o_ram_wdata = r_wdata;

endmodule
